// File: rtl/cache_port_arbiter_if.sv
// Requester and cache-side signals of the two-port cache arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface cache_port_arbiter_if;
  logic        req0, req1;
  logic [15:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        write0, write1;
  logic        ack0, ack1;
  logic [15:0] rdata;
  logic        err;
  logic        c_req;
  logic [15:0] c_addr;
  logic [15:0] c_wdata;
  logic        c_write;
  logic        c_done;
  logic [15:0] c_rdata;
  logic        busy;

  modport master (
    input  req0, req1, addr0, addr1, wdata0, wdata1, write0, write1, c_done, c_rdata,
    output ack0, ack1, rdata, err, c_req, c_addr, c_wdata, c_write, busy
  );

  modport slave (
    output req0, req1, addr0, addr1, wdata0, wdata1, write0, write1, c_done, c_rdata,
    input  ack0, ack1, rdata, err, c_req, c_addr, c_wdata, c_write, busy
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing a single-port word cache between fetch (port 0)
// and load/store (port 1); one access in flight, with timeout and misalignment errors.
module cache_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic                   clk,
  input logic                   reset,
  cache_port_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state, state_d;
  logic        last_grant, last_grant_d;
  logic        gnt, gnt_d;
  logic [15:0] cur_addr, cur_addr_d;
  logic [15:0] cur_wdata, cur_wdata_d;
  logic        cur_write, cur_write_d;
  logic [15:0] rdata_r, rdata_r_d;
  logic        err_r, err_r_d;
  logic [7:0]  cnt, cnt_d;
  logic        win;
  logic [15:0] win_addr;

  // On a tie the port that did not win last time is served.
  always_comb begin
    win      = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
    win_addr = win ? bus.addr1 : bus.addr0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      cur_write  <= 1'b0;
      rdata_r    <= '0;
      err_r      <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      gnt        <= gnt_d;
      cur_addr   <= cur_addr_d;
      cur_wdata  <= cur_wdata_d;
      cur_write  <= cur_write_d;
      rdata_r    <= rdata_r_d;
      err_r      <= err_r_d;
      cnt        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    gnt_d        = gnt;
    cur_addr_d   = cur_addr;
    cur_wdata_d  = cur_wdata;
    cur_write_d  = cur_write;
    rdata_r_d    = rdata_r;
    err_r_d      = err_r;
    cnt_d        = cnt;

    unique case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_d        = win;
          last_grant_d = win;
          cur_addr_d   = win_addr;
          cur_wdata_d  = win ? bus.wdata1 : bus.wdata0;
          cur_write_d  = win ? bus.write1 : bus.write0;
          if (win_addr[0]) begin
            err_r_d   = 1'b1;
            rdata_r_d = '0;
            state_d   = RESP;
          end else begin
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // c_done takes priority over a timeout expiring in the same cycle.
        if (bus.c_done) begin
          rdata_r_d = cur_write ? '0 : bus.c_rdata;
          err_r_d   = 1'b0;
          state_d   = RESP;
        end else if (cnt == TIMEOUT_CNT) begin
          rdata_r_d = '0;
          err_r_d   = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.c_req   = (state == ISSUE);
    bus.c_addr  = '0;
    bus.c_wdata = '0;
    bus.c_write = 1'b0;
    if (state == ISSUE || state == WAIT) begin
      bus.c_addr  = cur_addr;
      bus.c_wdata = cur_wdata;
      bus.c_write = cur_write;
    end
    bus.ack0  = (state == RESP) && !gnt;
    bus.ack1  = (state == RESP) && gnt;
    bus.rdata = (state == RESP) ? rdata_r : '0;
    bus.err   = (state == RESP) ? err_r : 1'b0;
    bus.busy  = (state != IDLE);
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: directed scenarios plus randomized
// transactions scored against a transaction-level reference model.
module tb_cache_port_arbiter;

  localparam int T = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cache_port_arbiter_if bus();

  cache_port_arbiter #(.TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit model_last;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    int          ack_cyc;
    logic [15:0] rd;
    bit          er;
    int          creq;
    logic [15:0] caddr;
    logic [15:0] cwdata;
    bit          cwr;
  } exp_t;

  // Observations of the most recent access.
  int          port, ac, cn, cc, bad, abs_ack;
  logic [15:0] rd, ca, cw;
  bit          er, cwr;

  // Transaction-level prediction from the arbitration and timing rules.
  function automatic exp_t predict(input bit r0, r1, last, input logic [15:0] a0, a1, d0, d1,
                                   input bit w0, w1, input int lat, input logic [15:0] crd);
    exp_t e;
    logic [15:0] a;
    bit w;
    e.port = (r0 && r1) ? (last ? 0 : 1) : (r1 ? 1 : 0);
    a = e.port == 1 ? a1 : a0;
    w = e.port == 1 ? w1 : w0;
    e.caddr = 16'h0; e.cwdata = 16'h0; e.cwr = 1'b0; e.rd = 16'h0;
    if (a[0]) begin
      e.ack_cyc = 1; e.er = 1'b1; e.creq = 0;
    end else begin
      e.creq = 1; e.caddr = a; e.cwdata = e.port == 1 ? d1 : d0; e.cwr = w;
      if (lat >= 1 && lat <= T + 1) begin
        e.ack_cyc = 2 + lat; e.er = 1'b0; e.rd = w ? 16'h0 : crd;
      end else begin
        e.ack_cyc = 3 + T; e.er = 1'b1;
      end
    end
    return e;
  endfunction

  // Drives one request (grant edge = first edge after the drive) and the cache
  // side, and records what the DUT did. lat = cycles after c_req for c_done (0 = never).
  task automatic run_access(input bit r0, r1, input logic [15:0] a0, a1, d0, d1,
                            input bit w0, w1, input int lat, input bit early,
                            input logic [15:0] crd);
    port = -1; ac = -1; rd = 16'h0; er = 1'b0; cn = 0; cc = -1; ca = 16'h0; cw = 16'h0;
    cwr = 1'b0; bad = 0; abs_ack = -1;
    @(negedge clk);
    if (bus.busy !== 1'b0) bad++;
    bus.req0 = r0; bus.req1 = r1; bus.addr0 = a0; bus.addr1 = a1;
    bus.wdata0 = d0; bus.wdata1 = d1; bus.write0 = w0; bus.write1 = w1;
    bus.c_done = 1'b0; bus.c_rdata = crd;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.c_done = 1'b0;
      bus.addr0 = 16'($urandom); bus.addr1 = 16'($urandom);
      bus.wdata0 = 16'($urandom); bus.wdata1 = 16'($urandom);
      bus.write0 = 1'($urandom); bus.write1 = 1'($urandom);
      if (bus.c_req) begin
        cn++; cc = k; ca = bus.c_addr; cw = bus.c_wdata; cwr = bus.c_write;
      end else if (cc > 0 && !(bus.ack0 || bus.ack1)) begin
        if (bus.c_addr !== ca || bus.c_wdata !== cw || bus.c_write !== cwr) bad++;
      end
      if (bus.busy !== 1'b1) bad++;
      if (bus.ack0 || bus.ack1) begin
        if (bus.ack0 && bus.ack1) bad++;
        port = bus.ack1 ? 1 : 0; ac = k; abs_ack = cyc; rd = bus.rdata; er = bus.err;
        if (port == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
        break;
      end else if (bus.rdata !== 16'h0 || bus.err !== 1'b0) begin
        bad++;
      end
      if (cc > 0 && ((lat > 0 && k == cc + lat) || (early && k == cc))) bus.c_done = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b0; bus.addr0 = 16'h0010; bus.addr1 = 16'h0;
    bus.wdata0 = 16'h0; bus.wdata1 = 16'h0; bus.write0 = 1'b0; bus.write1 = 1'b0;
    bus.c_done = 1'b0; bus.c_rdata = 16'h0;
    repeat (3) @(negedge clk);
    compared++; if ({bus.busy, bus.c_req, bus.ack0, bus.ack1, bus.err, bus.c_write} !== 6'b0) begin mismatched++; $display("FAIL reset_ctrl: got %b expected 000000", {bus.busy, bus.c_req, bus.ack0, bus.ack1, bus.err, bus.c_write}); end
    compared++; if ({bus.rdata, bus.c_addr, bus.c_wdata} !== 48'h0) begin mismatched++; $display("FAIL reset_data: got %h expected 0", {bus.rdata, bus.c_addr, bus.c_wdata}); end
    bus.req0 = 1'b0;
    reset = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_single_read();
    run_access(1, 0, 16'h0010, 16'h0, 16'h0, 16'h0, 0, 0, 1, 0, 16'hBEEF);
    model_last = 1'b0;
    compared++; if (cc !== 1) begin mismatched++; $display("FAIL read_creq_cycle: got %0d expected 1", cc); end
    compared++; if (ca !== 16'h0010) begin mismatched++; $display("FAIL read_c_addr: got %h expected 0010", ca); end
    compared++; if (port !== 0 || ac !== 3) begin mismatched++; $display("FAIL read_ack: got port %0d cycle %0d expected port 0 cycle 3", port, ac); end
    compared++; if (rd !== 16'hBEEF || er !== 1'b0) begin mismatched++; $display("FAIL read_data: got %h err %0d expected beef err 0", rd, er); end
    compared++; if (bad !== 0) begin mismatched++; $display("FAIL read_protocol: got %0d violations expected 0", bad); end
  endtask

  task automatic test_write();
    run_access(0, 1, 16'h0, 16'h0100, 16'h0, 16'h1234, 0, 1, 2, 1, 16'hAAAA);
    model_last = 1'b1;
    compared++; if (ca !== 16'h0100 || cw !== 16'h1234 || cwr !== 1'b1) begin mismatched++; $display("FAIL write_cache: got %h %h %0d expected 0100 1234 1", ca, cw, cwr); end
    compared++; if (port !== 1 || ac !== 4) begin mismatched++; $display("FAIL write_ack: got port %0d cycle %0d expected port 1 cycle 4", port, ac); end
    compared++; if (rd !== 16'h0 || er !== 1'b0 || bad !== 0) begin mismatched++; $display("FAIL write_resp: got %h err %0d bad %0d expected 0000 0 0", rd, er, bad); end
  endtask

  task automatic test_misaligned();
    run_access(1, 0, 16'h0003, 16'h0, 16'h0, 16'h0, 0, 0, 1, 0, 16'h5555);
    model_last = 1'b0;
    compared++; if (port !== 0 || ac !== 1 || er !== 1'b1) begin mismatched++; $display("FAIL misaligned_ack: got port %0d cycle %0d err %0d expected 0 1 1", port, ac, er); end
    compared++; if (cn !== 0 || bad !== 0) begin mismatched++; $display("FAIL misaligned_no_creq: got creq %0d bad %0d expected 0 0", cn, bad); end
  endtask

  task automatic test_timeout();
    int late_bad;
    run_access(1, 0, 16'h0020, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 16'h7777);
    model_last = 1'b0;
    compared++; if (ac !== T + 3 || er !== 1'b1 || rd !== 16'h0) begin mismatched++; $display("FAIL timeout_ack: got cycle %0d err %0d rdata %h expected %0d 1 0000", ac, er, rd, T + 3); end
    late_bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.c_done = (i < 2);
      if (bus.ack0 || bus.ack1 || bus.busy) late_bad++;
    end
    bus.c_done = 1'b0;
    compared++; if (late_bad !== 0) begin mismatched++; $display("FAIL late_done: got %0d spurious cycles expected 0", late_bad); end
    run_access(1, 0, 16'h0022, 16'h0, 16'h0, 16'h0, 0, 0, T + 1, 0, 16'h4321);
    compared++; if (ac !== T + 3 || er !== 1'b0 || rd !== 16'h4321) begin mismatched++; $display("FAIL done_at_limit: got cycle %0d err %0d rdata %h expected %0d 0 4321", ac, er, rd, T + 3); end
    run_access(1, 0, 16'h0024, 16'h0, 16'h0, 16'h0, 0, 0, T + 2, 0, 16'h4321);
    compared++; if (ac !== T + 3 || er !== 1'b1 || rd !== 16'h0) begin mismatched++; $display("FAIL done_past_limit: got cycle %0d err %0d rdata %h expected %0d 1 0000", ac, er, rd, T + 3); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int prev_abs;
    prev_abs = -1;
    for (int i = 0; i < 4; i++) begin
      e = predict(1, 1, model_last, 16'h0200 + 16'(i * 4), 16'h0300 + 16'(i * 4), 16'h0, 16'h0, 0, 0, 1, 16'h1111);
      run_access(1, 1, 16'h0200 + 16'(i * 4), 16'h0300 + 16'(i * 4), 16'h0, 16'h0, 0, 0, 1, 0, 16'h1111);
      model_last = e.port[0];
      compared++; if (port !== e.port || ca !== e.caddr) begin mismatched++; $display("FAIL tie_grant[%0d]: got port %0d addr %h expected %0d %h", i, port, ca, e.port, e.caddr); end
      if (prev_abs >= 0) begin
        compared++; if (abs_ack - prev_abs !== 4) begin mismatched++; $display("FAIL throughput[%0d]: got %0d cycles expected 4", i, abs_ack - prev_abs); end
      end
      prev_abs = abs_ack;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int quiet_bad;
    exp_t e;
    @(negedge clk);
    bus.req0 = 1'b1; bus.addr0 = 16'h0040; bus.write0 = 1'b0; bus.c_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1; bus.req0 = 1'b0;
    @(negedge clk);
    compared++; if ({bus.busy, bus.c_req, bus.ack0, bus.ack1, bus.err} !== 5'b0 || bus.c_addr !== 16'h0) begin mismatched++; $display("FAIL reset_mid: got busy %0d c_req %0d acks %0d%0d c_addr %h expected all 0", bus.busy, bus.c_req, bus.ack0, bus.ack1, bus.c_addr); end
    reset = 1'b0;
    model_last = 1'b1;
    quiet_bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1 || bus.busy) quiet_bad++;
    end
    compared++; if (quiet_bad !== 0) begin mismatched++; $display("FAIL reset_no_ack: got %0d active cycles expected 0", quiet_bad); end
    e = predict(1, 1, model_last, 16'h0050, 16'h0060, 16'h0, 16'h0, 0, 0, 2, 16'h2222);
    run_access(1, 1, 16'h0050, 16'h0060, 16'h0, 16'h0, 0, 0, 2, 0, 16'h2222);
    model_last = e.port[0];
    bus.req1 = 1'b0;
    compared++; if (port !== 0 || ca !== 16'h0050) begin mismatched++; $display("FAIL reset_tie: got port %0d addr %h expected 0 0050", port, ca); end
    run_access(1, 0, 16'h0070, 16'h0, 16'h0, 16'h0, 0, 0, 1, 0, 16'h3333);
    model_last = 1'b0;
    compared++; if (port !== 0 || ac !== 3 || rd !== 16'h3333 || er !== 1'b0) begin mismatched++; $display("FAIL reset_after_req: got port %0d cycle %0d rdata %h err %0d expected 0 3 3333 0", port, ac, rd, er); end
  endtask

  task automatic test_random();
    exp_t e;
    bit r0, r1, w0, w1, early;
    logic [15:0] a0, a1, d0, d1, crd;
    int lat, r;
    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(1, 3));
      r0 = r[0]; r1 = r[1];
      a0 = 16'($urandom); a1 = 16'($urandom);
      a0[0] = ($urandom_range(0, 3) == 0); a1[0] = ($urandom_range(0, 3) == 0);
      d0 = 16'($urandom); d1 = 16'($urandom); crd = 16'($urandom);
      w0 = 1'($urandom); w1 = 1'($urandom); early = 1'($urandom);
      lat = int'($urandom_range(1, 7));
      e = predict(r0, r1, model_last, a0, a1, d0, d1, w0, w1, lat, crd);
      run_access(r0, r1, a0, a1, d0, d1, w0, w1, lat, early, crd);
      model_last = e.port[0];
      compared++; if (port !== e.port || ac !== e.ack_cyc) begin mismatched++; $display("FAIL rand_ack[%0d]: got port %0d cycle %0d expected %0d %0d", i, port, ac, e.port, e.ack_cyc); end
      compared++; if (rd !== e.rd || er !== e.er) begin mismatched++; $display("FAIL rand_resp[%0d]: got %h err %0d expected %h err %0d", i, rd, er, e.rd, e.er); end
      compared++; if (cn !== e.creq || ca !== e.caddr || cw !== e.cwdata || cwr !== e.cwr) begin mismatched++; $display("FAIL rand_cache[%0d]: got n %0d %h %h %0d expected n %0d %h %h %0d", i, cn, ca, cw, cwr, e.creq, e.caddr, e.cwdata, e.cwr); end
      compared++; if (bad !== 0) begin mismatched++; $display("FAIL rand_protocol[%0d]: got %0d violations expected 0", i, bad); end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Sequencing controller that shares the single-port word cache between two requesters: instruction fetch (port 0) and load/store (port 1). It arbitrates round-robin and latches the winning request. It then drives one cache access, waits for the cache to complete, and returns read data or an error to the granted requester. It sits between the core's fetch and memory stages and the cache, and is the only master on the cache's request interface.

## Interface

- `TIMEOUT`, default 255: cycles to wait for `c_done` before aborting with an error; legal range 1..255.
- `clk` input 1: single clock; all logic is rising-edge.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `req0`, `req1` input 1: request from port 0 / port 1; held high until the matching `ack`.
- `addr0`, `addr1` input 16: byte address; must be even.
- `wdata0`, `wdata1` input 16: write data.
- `write0`, `write1` input 1: 1 = write, 0 = read.
- `ack0`, `ack1` output 1: one-cycle completion pulse to port 0 / port 1.
- `rdata` output 16: read data, valid in the `ack` cycle.
- `err` output 1: valid in the `ack` cycle; 1 = misaligned address or timeout.
- `c_req` output 1: one-cycle access strobe to the cache.
- `c_addr` output 16: cache address.
- `c_wdata` output 16: cache write data.
- `c_write` output 1: cache write select.
- `c_done` input 1: cache completion pulse.
- `c_rdata` input 16: cache read data, valid with `c_done`.
- `busy` output 1: high in every state except IDLE.

## Operation

States: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - Arbitrate among requests.
    - Only one `req` high: that port wins.
    - Both high: the port other than `last_grant` wins.
    - `last_grant` resets to 1, so port 0 wins the first tie.
  - On a grant:
    - Latch `addr`, `wdata` and `write` into `cur_*`, store `gnt`, and update `last_grant`.
    - If `cur_addr[0]` is 1, set `err_r`=1 and go to RESP; the cache is never touched.
    - Otherwise go to ISSUE.
  - `c_done` is ignored in IDLE.
- **ISSUE**
  - `c_req`=1 for exactly this cycle, with `c_addr`/`c_wdata`/`c_write` driven from the latched fields.
  - Clear the timeout counter.
  - Go to WAIT.
- **WAIT**
  - Drive `c_addr`/`c_wdata`/`c_write` from the latched fields and hold them stable.
  - On `c_done`=1: capture `c_rdata` into `rdata_r` (reads only; writes set `rdata_r`=0), set `err_r`=0, go to RESP.
  - Otherwise increment the 8-bit counter. When the counter equals `TIMEOUT`, set `err_r`=1, `rdata_r`=0, and go to RESP.
  - If `c_done` arrives in the same cycle the counter reaches `TIMEOUT`, `c_done` wins and there is no error.
- **RESP**
  - `ack[gnt]`=1 for one cycle; `rdata`=`rdata_r`; `err`=`err_r`.
  - Go to IDLE.
- **Latching.** Request fields are latched at grant, so changes on the requester inputs after grant have no effect on the access in flight.
- **Stale `c_done`.** A `c_done` arriving after a timeout (i.e. in IDLE/ISSUE/RESP) is ignored.
- **Reset**, including mid-access, forces:
  - State IDLE, `last_grant`=1, counter 0.
  - Outputs: `c_req`=0, `c_write`=0, `c_addr`=0, `c_wdata`=0, `ack0`=`ack1`=0, `rdata`=0, `err`=0, `busy`=0.
  - No ack is ever produced for an access in flight at reset.
- **`rdata`/`err` outside RESP** are driven 0.

## Timing

- **Request accepted:** a request sampled in IDLE at edge N gives ISSUE in cycle N+1, with `c_req` high.
- **Cache contract:** `c_done` comes no earlier than the cycle after `c_req`. `c_done` in the `c_req` cycle is ignored.
- **Access latency:** with the cache's `c_done` in cycle N+1+L (L≥1), `ack` is in cycle N+2+L. Minimum request-to-ack is 3 cycles.
- **Misaligned address:** `ack` with `err`=1 in cycle N+1; no `c_req`.
- **Timeout:** `ack` in cycle N+3+`TIMEOUT`.
- **Back-to-back:** a request held or newly asserted is arbitrated in the IDLE cycle after RESP. Throughput is one access per 4 cycles at L=1.
- **Requester protocol:** the requester must drop `req` in the cycle after `ack`; a `req` still high in the following IDLE is treated as a new request.

## Test plan

- **Single read:** after reset, `req0`=1, `addr0`=0x0010, `write0`=0; cache returns `c_done` one cycle after `c_req` with `c_rdata`=0xBEEF → `c_req` in cycle 1 with `c_addr`=0x0010, `ack0` in cycle 3 with `rdata`=0xBEEF, `err`=0, `ack1`=0.
- **Tie / round-robin:** `req0` and `req1` both held continuously, each dropped for one cycle after its ack → grants alternate port 0, 1, 0, 1; each ack matches that port's `addr` on `c_addr`.
- **Write:** `req1`=1, `addr1`=0x0100, `wdata1`=0x1234, `write1`=1 → `c_write`=1 and `c_wdata`=0x1234 with `c_req`; `ack1` with `rdata`=0, `err`=0.
- **Misaligned:** `req0`=1, `addr0`=0x0003 → `ack0` with `err`=1 the cycle after grant; `c_req` never asserted.
- **Timeout:** `TIMEOUT`=4, `c_done` never asserted → `ack` with `err`=1 exactly 7 cycles after the grant edge. A late `c_done` afterwards produces no ack.
- **Reset mid-access:** assert `reset` during WAIT → the next cycle has `busy`=0, `c_req`=0, no ack. A following `req0` is accepted normally, and port 0 wins a subsequent tie.
